// File: rtl/param_down_timer.sv
// Loadable down-counting timer: terminal-count pulse, one-shot or auto-reload, start/stop control.
// Optional prescaler enabled by defining PARAM_DOWN_TIMER_PRESCALE_EN.
module param_down_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             en,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    if (WIDTH < 2) begin : g_chk_width
        $error("param_down_timer: WIDTH must be >= 2");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("param_down_timer: PRESCALE must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload_reg, reload_n;
    logic             mode_reg, mode_n;
    logic             tc_n, done_n;
    logic             tick;

`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps, ps_n;

    assign tick = en && (ps == PS_LAST);

    // The prescaler only advances while counting; start, stop and reset clear it.
    always_comb begin
        ps_n = ps;
        if (start) begin
            ps_n = '0;
        end else if (state == RUN) begin
            if (stop) begin
                ps_n = '0;
            end else if (en) begin
                ps_n = (ps == PS_LAST) ? '0 : ps + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps <= '0;
        end else begin
            ps <= ps_n;
        end
    end
`else
    assign tick = en;
`endif

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        mode_n   = mode_reg;
        done_n   = done;
        tc_n     = 1'b0;

        if (start) begin
            count_n  = load_val;
            reload_n = load_val;
            mode_n   = auto_reload;
            done_n   = 1'b0;
            if (load_val != '0) begin
                state_n = RUN;
            end else begin
                // A zero load completes immediately, even in auto-reload mode.
                state_n = DONE;
                tc_n    = 1'b1;
                done_n  = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (stop) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count_n = count - WIDTH'(1);
                        end else begin
                            tc_n = 1'b1;
                            if (mode_reg) begin
                                count_n = reload_reg;
                            end else begin
                                count_n = '0;
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            mode_reg   <= mode_n;
            busy       <= (state_n == RUN);
            tc         <= tc_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_param_down_timer.sv
// Directed self-checking bench for param_down_timer (WIDTH=8, PRESCALE=4).
module tb_param_down_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] load_val;
    logic         auto_reload;
    logic         en;
    logic         stop;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    int checks = 0;
    int errors = 0;

    param_down_timer #(.WIDTH(W), .PRESCALE(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .load_val(load_val),
        .auto_reload(auto_reload),
        .en(en),
        .stop(stop),
        .count(count),
        .busy(busy),
        .tc(tc),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_val = '0; auto_reload = 1'b0; en = 1'b0; stop = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tc", 32'(tc), 0);
        chk("rst_done", 32'(done), 0);

        // One-shot, load 5
        rst = 1'b0;
        start = 1'b1; load_val = 8'd5; auto_reload = 1'b0; en = 1'b1;
        step();
        start = 1'b0;
        chk("os_load_count", 32'(count), 5);
        chk("os_load_busy", 32'(busy), 1);
        chk("os_load_tc", 32'(tc), 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("os_count", 32'(count), 32'(5 - k));
            chk("os_tc", 32'(tc), (k == 5) ? 1 : 0);
        end
        chk("os_done", 32'(done), 1);
        chk("os_busy", 32'(busy), 0);
        step();
        chk("os_hold_count", 32'(count), 0);
        chk("os_hold_tc", 32'(tc), 0);
        chk("os_hold_done", 32'(done), 1);

        // Auto-reload, load 3
        start = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
        step();
        start = 1'b0;
        chk("ar_load_count", 32'(count), 3);
        chk("ar_load_done", 32'(done), 0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("ar_count", 32'(count), (k % 3 == 0) ? 3 : 32'(3 - (k % 3)));
            chk("ar_tc", 32'(tc), (k % 3 == 0) ? 1 : 0);
            chk("ar_done", 32'(done), 0);
            chk("ar_busy", 32'(busy), 1);
        end

        // Enable toggling every cycle, load 6: tc 12 cycles after start
        start = 1'b1; load_val = 8'd6; auto_reload = 1'b0; en = 1'b0;
        step();
        start = 1'b0;
        chk("en_load_count", 32'(count), 6);
        for (int k = 1; k <= 12; k++) begin
            en = (k % 2 == 0);
            step();
            chk("en_count", 32'(count), 32'(6 - k / 2));
            chk("en_tc", 32'(tc), (k == 12) ? 1 : 0);
        end
        chk("en_done", 32'(done), 1);

        // Stop at 4, then start+stop together
        start = 1'b1; load_val = 8'd9; en = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        chk("stop_pre_count", 32'(count), 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_count", 32'(count), 4);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_tc", 32'(tc), 0);
        chk("stop_done", 32'(done), 0);
        step();
        chk("stop_hold_count", 32'(count), 4);
        start = 1'b1; stop = 1'b1; load_val = 8'd2;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_count", 32'(count), 2);
        chk("ss_busy", 32'(busy), 1);
        step();
        chk("ss_count1", 32'(count), 1);
        step();
        chk("ss_count0", 32'(count), 0);
        chk("ss_tc", 32'(tc), 1);
        chk("ss_done", 32'(done), 1);

        // Zero load in auto-reload mode
        start = 1'b1; load_val = 8'd0; auto_reload = 1'b1;
        step();
        start = 1'b0;
        chk("z_tc", 32'(tc), 1);
        chk("z_done", 32'(done), 1);
        chk("z_busy", 32'(busy), 0);
        chk("z_count", 32'(count), 0);
        step();
        chk("z_tc2", 32'(tc), 0);
        chk("z_done2", 32'(done), 1);
        step();
        chk("z_tc3", 32'(tc), 0);

        // Reset mid-count at 7
        start = 1'b1; load_val = 8'd10; auto_reload = 1'b0;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        chk("r_pre_count", 32'(count), 7);
        rst = 1'b1;
        step();
        chk("r_count", 32'(count), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_tc", 32'(tc), 0);
        chk("r_done", 32'(done), 0);
        rst = 1'b0;
        step();
        chk("r_idle_count", 32'(count), 0);
        chk("r_idle_busy", 32'(busy), 0);
        chk("r_idle_tc", 32'(tc), 0);

`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
        // Prescale 4, load 2: tc 8 cycles after start
        start = 1'b1; load_val = 8'd2; en = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("ps_count", 32'(count), 32'(2 - k / 4));
            chk("ps_tc", 32'(tc), (k == 8) ? 1 : 0);
        end
`else
        // Without prescaler, load 2 finishes 2 cycles after start
        start = 1'b1; load_val = 8'd2; en = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("np_count", 32'(count), 32'(2 - k));
            chk("np_tc", 32'(tc), (k == 2) ? 1 : 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
